// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state and access-width encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_t;

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: valid/ready data-memory bus between the LSU (master) and memory (slave).
interface load_store_unit_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store strobe/lane replication and load byte/halfword extract with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic        is_b, is_h, sx;
    logic [7:0]  b;
    logic [15:0] h;

    // Anything that is neither a byte nor a halfword encoding (incl. reserved) is a word.
    assign is_b = funct3 == MW_B || funct3 == MW_BU;
    assign is_h = funct3 == MW_H || funct3 == MW_HU;
    assign sx   = funct3 == MW_B || funct3 == MW_H;

    assign b = rdata[{lane, 3'b000} +: 8];
    assign h = lane[1] ? rdata[31:16] : rdata[15:0];

    assign wstrb     = is_b ? 4'b0001 << lane : is_h ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    assign rdata_ext = is_b ? {{24{sx & b[7]}}, b} : is_h ? {{16{sx & h[15]}}, h} : rdata;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine stalling the CPU while a memory access is outstanding.
// Define LSU_MISALIGN_TRAP_EN to fail misaligned H/W accesses in IDLE without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_error,
    load_store_unit_if.master mem
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [2:0]  f3_q, f3_sel;
    logic [1:0]  lane_q, lane_sel;
    logic [15:0] cnt;
    logic [3:0]  strb;
    logic [31:0] wdata_rep, rdata_ext;
    logic        misal;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = (cpu_funct3 == MW_H || cpu_funct3 == MW_HU) ? cpu_addr[0] :
                   !(cpu_funct3 == MW_B || cpu_funct3 == MW_BU) && cpu_addr[1:0] != 2'b00;
`else
    assign misal = 1'b0;
`endif

    // Stores are aligned from the live CPU inputs at capture; loads extract with the latched lane.
    assign f3_sel   = state == IDLE ? cpu_funct3 : f3_q;
    assign lane_sel = state == IDLE ? cpu_addr[1:0] : lane_q;

    lsu_lane_align u_align (
        .funct3    (f3_sel),
        .lane      (lane_sel),
        .wdata     (cpu_wdata),
        .rdata     (mem.mem_resp_rdata),
        .wstrb     (strb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign cpu_stall         = (state == IDLE && cpu_valid) || state == REQ || state == RESP;
    assign cpu_done          = state == DONE;
    assign mem.mem_req_valid = state == REQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            f3_q          <= '0;
            lane_q        <= '0;
            cnt           <= '0;
            cpu_rdata     <= '0;
            cpu_error     <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_valid) begin
                    f3_q          <= cpu_funct3;
                    lane_q        <= cpu_addr[1:0];
                    cnt           <= '0;
                    cpu_rdata     <= '0;
                    cpu_error     <= misal;
                    mem.mem_we    <= cpu_write;
                    mem.mem_addr  <= {cpu_addr[31:2], 2'b00};
                    mem.mem_wdata <= wdata_rep;
                    mem.mem_wstrb <= cpu_write ? strb : 4'b0000;
                    state         <= misal ? DONE : REQ;
                end
                REQ: if (mem.mem_req_ready) begin
                    cnt   <= '0;
                    state <= mem.mem_we ? DONE : RESP;
                end else if (cnt == TO_LAST) begin
                    cpu_error <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (mem.mem_resp_valid) begin
                    cpu_rdata <= rdata_ext;
                    state     <= DONE;
                end else if (cnt == TO_LAST) begin
                    cpu_error <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    cpu_error <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store engine between the CPU datapath and a handshaked data memory. It replaces the combinational word-only data memory path. It accepts one access per transaction from the execute stage: address from the ALU result, store data from rs2, and funct3. It drives a valid/ready memory request with byte strobes and returns sign/zero-extended load data to the register write-back mux. The CPU is stalled while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles in REQ or RESP before the access is aborted with cpu_error; legal range 1..65535.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cpu_valid  input  1  execute stage presents a load/store this cycle
cpu_write  input  1  1 = store (SB/SH/SW), 0 = load
cpu_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_addr  input  32  byte address (ALU result)
cpu_wdata  input  32  store data (rs2)
cpu_stall  output  1  hold PC and pipeline
cpu_done  output  1  one-cycle pulse: access complete
cpu_rdata  output  32  extended load data; valid when cpu_done=1
cpu_error  output  1  with cpu_done: timeout or misaligned access
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  write request
mem_addr  output  32  word address, bits [1:0] forced to 00
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte enables; 0000 on reads
mem_resp_valid  input  1  read data valid (reads only)
mem_resp_rdata  input  32  read word

Behaviour:
- FSM states (in shared enum): IDLE, REQ, RESP, DONE.
- Reset: state=IDLE; all outputs 0 (cpu_rdata, mem_addr, mem_wdata, mem_wstrb, timeout counter). Reset mid-operation abandons the access at once. No cpu_done is produced. A late mem_resp_valid arriving in IDLE is ignored.
- IDLE: on cpu_valid, latch write/funct3/addr/wdata and go to REQ. cpu_stall = cpu_valid (combinational) so the PC holds in the capture cycle.
- REQ: mem_req_valid=1. The address, data and strobes are registered and stay stable until the handshake. On mem_req_ready, go to DONE for a write or RESP for a read.
- RESP: on mem_resp_valid, register the extracted and extended data into cpu_rdata, then go to DONE.
- DONE: cpu_done=1 and cpu_stall=0 for one cycle, then go to IDLE. cpu_valid in DONE is ignored, because the CPU has moved on.
- cpu_stall=1 throughout REQ and RESP.
- Minimum latency: store 3 cycles (capture, handshake, done); load 4 cycles, or more with memory wait states.
- Store lanes, indexed by addr[1:0]:
  - SB: strobe = 0001<<a; data = byte replicated x4.
  - SH: strobe = 0011<<(a[1]*2); data = halfword replicated x2.
  - SW: strobe = 1111.
- Load extraction:
  - B/BU: byte lane addr[1:0]; sign-extend for B, zero-extend for BU.
  - H/HU: halfword addr[1]; sign-extend for H, zero-extend for HU.
  - W: full word.
- Reserved funct3 values (011, 110, 111) are treated as W.
- Timeout: a 16-bit counter clears on entering REQ and on entering RESP and increments each cycle spent in either. When the count reaches TIMEOUT_CYCLES without the awaited handshake, go to DONE with cpu_error=1 and cpu_rdata=0. mem_req_valid drops on the same transition.
- cpu_error=0 on every normal completion.
- The memory must not assert mem_resp_valid in the same cycle as the read handshake; the earliest legal response is the cycle after.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: an H/HU/SH access with addr[0]=1, or a W/SW access with addr[1:0]!=00, is detected in IDLE. It goes straight to DONE with cpu_error=1 and cpu_rdata=0. No memory request is issued and memory is not modified.
- Undefined: there is no check. The halfword access uses lane addr[1]; the word access ignores addr[1:0].

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_t (IDLE, REQ, RESP, DONE).
  - mem_width_t funct3 encodings (MW_B=000, MW_H=001, MW_W=010, MW_BU=100, MW_HU=101).
- One natural sub-module, lsu_lane_align. It is purely combinational and produces the store strobe/data and the load extract/extend from funct3, addr[1:0] and the data. The FSM and counter stay in load_store_unit.

Test Plan:
- LB at 0x13, memory word 0x80FF7F01, 1-cycle response -> mem_addr 0x10, mem_wstrb 0000, cpu_rdata 0xFFFFFF80, cpu_done on the 4th cycle. LBU at the same address -> 0x00000080.
- LH at 0x2 on word 0x80FF7F01 -> 0xFFFF80FF. LHU at 0x0 -> 0x00007F01.
- SB at 0x5 with wdata 0x123456AB, ready held for 2 cycles -> mem_addr 0x4, wstrb 0010, mem_wdata 0xABABABAB, stable until the handshake. SH at 0x6 -> wstrb 1100, wdata 0x56AB56AB.
- TIMEOUT_CYCLES=4, mem_req_ready never asserted -> after 4 REQ cycles: cpu_done=1, cpu_error=1, cpu_rdata=0, back to IDLE.
- Reset asserted in RESP, then mem_resp_valid pulses in IDLE -> no cpu_done, all outputs 0. A next LW at 0x8 completes normally.
- With LSU_MISALIGN_TRAP_EN defined, SW at 0x6 -> no mem_req_valid, cpu_done and cpu_error on the 2nd cycle. Without it -> a normal store at mem_addr 0x4 with wstrb 1111.
